// File: rtl/control_path_seq.sv
// Control-path sequencer: fetch/decode of a small accumulator ISA with a return stack,
// stall slots for datapath load/store and a UART vector that saves the pc before jumping.
module control_path_seq #(
  parameter int AW = 12,
  parameter int DW = 16,
  parameter int OPW = 4,
  parameter int STK_DEPTH = 4,
  parameter logic [AW-1:0] BOOT_ADDR = {AW{1'b0}},
  parameter logic [AW-1:0] VEC_ADDR = 12'h7F6,
  parameter logic [AW-1:0] VEC_SAVE = 12'h7FF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] mem_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [AW-1:0] ls_addr,
  input  logic          ls_we,
  input  logic [DW-1:0] ls_wdata,
  input  logic          flag_z,
  input  logic          flag_n,
  input  logic          byte_ready,
  output logic          byte_ack,
  output logic [DW-1:0] ir,
  output logic          st_normal,
  output logic          st_exec1,
  output logic          st_exec2,
  output logic          is_jmp,
  output logic          is_jmi,
  output logic          is_jeq,
  output logic          is_stp,
  output logic          is_uart,
  output logic          float_mode,
  output logic          halted,
  output logic          stk_err
);

  localparam int SPW = $clog2(STK_DEPTH + 1);
  localparam int IW  = (STK_DEPTH > 1) ? $clog2(STK_DEPTH) : 1;
  localparam logic [SPW-1:0] SP_FULL  = SPW'(STK_DEPTH);
  localparam logic [SPW-1:0] SP_EMPTY = SPW'(0);
  localparam logic [SPW-1:0] SP_ONE   = SPW'(1);

  localparam logic [OPW-1:0] OP_STL0 = OPW'(0);
  localparam logic [OPW-1:0] OP_STL1 = OPW'(1);
  localparam logic [OPW-1:0] OP_FLT  = OPW'(2);
  localparam logic [OPW-1:0] OP_UART = OPW'(3);
  localparam logic [OPW-1:0] OP_JMP  = OPW'(4);
  localparam logic [OPW-1:0] OP_JMI  = OPW'(5);
  localparam logic [OPW-1:0] OP_JEQ  = OPW'(6);
  localparam logic [OPW-1:0] OP_STP  = OPW'(7);
  localparam logic [OPW-1:0] OP_CALL = OPW'(8);
  localparam logic [OPW-1:0] OP_RET  = OPW'(9);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_NORMAL = 2'd1,
    S_EXEC1  = 2'd2,
    S_EXEC2  = 2'd3
  } state_t;

  state_t          state, next_state;
  logic [AW-1:0]   pc, next_pc, pc_inc, target;
  logic [OPW-1:0]  opcode, ir_op;
  logic [AW-1:0]   stk [STK_DEPTH];
  logic [SPW-1:0]  sp;
  logic [IW-1:0]   top_idx;
  logic            we_c, ack_c;
  logic            load_ir, do_float, do_stp, do_push, do_pop, do_err;

  always_comb begin
    opcode     = mem_rdata[DW-1 -: OPW];
    target     = mem_rdata[AW-1:0];
    pc_inc     = pc + AW'(1);
    top_idx    = IW'(sp - SP_ONE);
    next_state = state;
    next_pc    = pc;
    mem_addr   = pc;
    we_c       = 1'b0;
    ack_c      = 1'b0;
    mem_wdata  = {DW{1'b0}};
    load_ir    = 1'b0;
    do_float   = 1'b0;
    do_stp     = 1'b0;
    do_push    = 1'b0;
    do_pop     = 1'b0;
    do_err     = 1'b0;
    case (state)
      S_FETCH: next_state = S_NORMAL;
      S_NORMAL: begin
        if (halted) begin
          next_state = S_NORMAL;
        end else if (byte_ready) begin
          // The fetched word is dropped; pc is saved so the handler can resume it.
          we_c       = 1'b1;
          ack_c      = 1'b1;
          mem_addr   = VEC_SAVE;
          mem_wdata  = {pc, {(DW-AW){1'b0}}};
          next_pc    = VEC_ADDR;
          next_state = S_FETCH;
        end else begin
          load_ir = 1'b1;
          next_pc = pc_inc;
          case (opcode)
            OP_STL0, OP_STL1, OP_UART: next_state = S_EXEC1;
            OP_FLT:  do_float = 1'b1;
            OP_JMP:  next_pc = target;
            OP_JMI:  if (flag_n) next_pc = target; else next_pc = pc_inc;
            OP_JEQ:  if (flag_z) next_pc = target; else next_pc = pc_inc;
            OP_STP: begin
              do_stp  = 1'b1;
              next_pc = pc;
            end
            OP_CALL: begin
              next_pc = target;
              if (sp == SP_FULL) do_err = 1'b1; else do_push = 1'b1;
            end
            OP_RET: begin
              if (sp == SP_EMPTY) begin
                do_err = 1'b1;
              end else begin
                do_pop  = 1'b1;
                next_pc = stk[top_idx];
              end
            end
            default: next_pc = pc_inc;
          endcase
          mem_addr = next_pc;
        end
      end
      S_EXEC1: begin
        mem_addr   = ls_addr;
        we_c       = ls_we;
        mem_wdata  = ls_wdata;
        next_state = S_EXEC2;
      end
      S_EXEC2: next_state = S_NORMAL;
      default: next_state = S_FETCH;
    endcase
  end

  // Reset must also squash a store or vector write already decoded this cycle.
  assign mem_we   = we_c & ~rst;
  assign byte_ack = ack_c & ~rst;

  assign st_normal = (state == S_NORMAL);
  assign st_exec1  = (state == S_EXEC1);
  assign st_exec2  = (state == S_EXEC2);
  assign ir_op     = ir[DW-1 -: OPW];
  assign is_jmp    = (ir_op == OP_JMP);
  assign is_jmi    = (ir_op == OP_JMI);
  assign is_jeq    = (ir_op == OP_JEQ);
  assign is_stp    = (ir_op == OP_STP);
  assign is_uart   = (ir_op == OP_UART);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_FETCH;
      pc         <= BOOT_ADDR;
      ir         <= {DW{1'b0}};
      float_mode <= 1'b0;
      halted     <= 1'b0;
      stk_err    <= 1'b0;
      sp         <= SP_EMPTY;
    end else begin
      state <= next_state;
      pc    <= next_pc;
      if (load_ir)  ir <= mem_rdata;
      if (do_float) float_mode <= ~float_mode;
      if (do_stp)   halted <= 1'b1;
      if (do_err)   stk_err <= 1'b1;
      if (do_push) begin
        stk[IW'(sp)] <= pc_inc;
        sp           <= sp + SP_ONE;
      end else if (do_pop) begin
        sp <= sp - SP_ONE;
      end
    end
  end

endmodule

// File: tb/tb_control_path_seq.sv
// Bench for control_path_seq: an instruction-level interpreter predicts every bus transaction
// of NORMAL/EXEC1 cycles; a monitor pops and compares them as the DUT presents them.
module tb_control_path_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] mem_rdata;
  logic [11:0] mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [11:0] ls_addr = 12'h000;
  logic        ls_we = 1'b0;
  logic [15:0] ls_wdata = 16'h0000;
  logic        flag_z = 1'b0, flag_n = 1'b0, byte_ready = 1'b0;
  logic        byte_ack;
  logic [15:0] ir;
  logic        st_normal, st_exec1, st_exec2;
  logic        is_jmp, is_jmi, is_jeq, is_stp, is_uart;
  logic        float_mode, halted, stk_err;

  control_path_seq dut (
    .clk(clk), .rst(rst), .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .ls_addr(ls_addr), .ls_we(ls_we), .ls_wdata(ls_wdata),
    .flag_z(flag_z), .flag_n(flag_n), .byte_ready(byte_ready), .byte_ack(byte_ack), .ir(ir),
    .st_normal(st_normal), .st_exec1(st_exec1), .st_exec2(st_exec2), .is_jmp(is_jmp),
    .is_jmi(is_jmi), .is_jeq(is_jeq), .is_stp(is_stp), .is_uart(is_uart),
    .float_mode(float_mode), .halted(halted), .stk_err(stk_err)
  );

  always #5 clk = ~clk;

  bit [15:0] mem  [4096];
  bit [15:0] mmem [4096];

  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr];
    if (mem_we) mem[mem_addr] = mem_wdata;
  end

  typedef struct packed {
    logic [11:0] addr;
    logic        we;
    logic [15:0] wdata;
    logic        ack;
    logic [15:0] ir;
    logic        halted;
    logic        err;
    logic        fm;
    logic        ex1;
  } txn_t;

  txn_t exp_q[$];
  int   checks = 0, failures = 0;
  int   vec_after = 1000, popped = 0;
  bit   active = 1'b0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] dec(logic [15:0] w);
    logic [3:0] op;
    op = w[15:12];
    return {op == 4'd4, op == 4'd5, op == 4'd6, op == 4'd7, op == 4'd3};
  endfunction

  // Instruction-level interpreter: one step per executed instruction, vector or halted cycle.
  task automatic gen_model(int ntx, logic fz, logic fn, logic [11:0] lsa, logic lswe, logic [15:0] lswd);
    logic [11:0] pc, nxt, t;
    logic [15:0] w, cur_ir;
    logic [3:0]  op;
    logic        fm, hlt, err, pending, used, stall;
    logic [11:0] stk[$];
    txn_t        tx;
    int          cnt;
    pc = 12'h000; cur_ir = 16'h0000; fm = 1'b0; hlt = 1'b0; err = 1'b0;
    pending = (vec_after == 0); used = pending; cnt = 0;
    for (int i = 0; i < 4096; i++) mmem[i] = mem[i];
    while (cnt < ntx) begin
      w = mmem[pc]; op = w[15:12]; t = w[11:0]; stall = 1'b0;
      tx = '{addr: pc, we: 1'b0, wdata: 16'h0000, ack: 1'b0, ir: cur_ir,
             halted: hlt, err: err, fm: fm, ex1: 1'b0};
      if (hlt) begin
        tx.addr = pc;
      end else if (pending) begin
        pending = 1'b0;
        tx.addr = 12'h7FF; tx.we = 1'b1; tx.wdata = {pc, 4'h0}; tx.ack = 1'b1;
        mmem[12'h7FF] = {pc, 4'h0};
        pc = 12'h7F6;
      end else begin
        nxt = pc + 12'd1;
        case (op)
          4'd0, 4'd1, 4'd3: stall = 1'b1;
          4'd2: fm = ~fm;
          4'd4: nxt = t;
          4'd5: if (fn) nxt = t;
          4'd6: if (fz) nxt = t;
          4'd7: begin hlt = 1'b1; nxt = pc; end
          4'd8: begin
            if (stk.size() == 4) err = 1'b1; else stk.push_back(pc + 12'd1);
            nxt = t;
          end
          4'd9: if (stk.size() == 0) err = 1'b1; else nxt = stk.pop_back();
          default: ;
        endcase
        tx.addr = nxt;
        cur_ir = w;
        pc = nxt;
      end
      exp_q.push_back(tx); cnt++;
      if (!used && cnt == vec_after) begin pending = 1'b1; used = 1'b1; end
      if (stall && cnt < ntx) begin
        tx = '{addr: lsa, we: lswe, wdata: lswd, ack: 1'b0, ir: cur_ir,
               halted: hlt, err: err, fm: fm, ex1: 1'b1};
        if (lswe) mmem[lsa] = lswd;
        exp_q.push_back(tx); cnt++;
        if (!used && cnt == vec_after) begin pending = 1'b1; used = 1'b1; end
      end
    end
  endtask

  // Monitor: compares every NORMAL/EXEC1 cycle against the next predicted transaction.
  initial begin
    txn_t e;
    forever begin
      @(negedge clk);
      if (active && !rst && (st_normal || st_exec1) && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        popped++;
        chk("mem_addr", mem_addr, e.addr);
        chk("mem_we", mem_we, e.we);
        if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
        chk("byte_ack", byte_ack, e.ack);
        chk("ir", ir, e.ir);
        chk("status", {halted, stk_err, float_mode}, {e.halted, e.err, e.fm});
        chk("decode", {is_jmp, is_jmi, is_jeq, is_stp, is_uart}, dec(e.ir));
        chk("state", {st_normal, st_exec1, st_exec2}, {~e.ex1, e.ex1, 1'b0});
        if (popped == vec_after) begin
          @(posedge clk); #1; byte_ready = 1'b1;
        end else if (byte_ack) begin
          @(posedge clk); #1; byte_ready = 1'b0;
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_ack", byte_ack, 1'b0);
    @(posedge clk); #1; byte_ready = 1'b0;
    @(negedge clk);
    chk("rst_state", {st_normal, st_exec1, st_exec2}, 3'b000);
    chk("rst_ir", ir, 16'h0000);
    chk("rst_status", {halted, stk_err, float_mode}, 3'b000);
    chk("rst_addr", mem_addr, 12'h000);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
  endtask

  task automatic run(int ntx, logic fz, logic fn, logic [11:0] lsa, logic lswe, logic [15:0] lswd, int va);
    int cyc;
    vec_after = va; popped = 0;
    flag_z = fz; flag_n = fn; ls_addr = lsa; ls_we = lswe; ls_wdata = lswd;
    gen_model(ntx, fz, fn, lsa, lswe, lswd);
    byte_ready = (va == 0);
    @(posedge clk); #1; active = 1'b1; rst = 1'b0;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 400) begin
      @(posedge clk); cyc++;
    end
    if (exp_q.size() > 0) begin
      checks++; failures++;
      $display("FAIL timeout: %0d transactions outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    active = 1'b0;
    do_reset();
  endtask

  initial begin
    logic [3:0] op;
    do_reset();
    // JMP from boot, then JEQ not taken / taken
    clear_mem();
    mem[0] = 16'h4005; mem[5] = 16'h6010; mem[6] = 16'h7000; mem[16] = 16'h7000;
    run(5, 1'b0, 1'b0, 12'h000, 1'b0, 16'h0000, 1000);
    clear_mem();
    mem[0] = 16'h4005; mem[5] = 16'h6010; mem[6] = 16'h7000; mem[16] = 16'h7000;
    run(5, 1'b1, 1'b0, 12'h000, 1'b0, 16'h0000, 1000);
    // stall slot with datapath store
    clear_mem();
    mem[0] = 16'h0020; mem[1] = 16'h7000;
    run(5, 1'b0, 1'b0, 12'h020, 1'b1, 16'hBEEF, 1000);
    // five nested CALLs then five RETs
    clear_mem();
    mem[12'h000] = 16'h8010; mem[12'h010] = 16'h8020; mem[12'h020] = 16'h8030;
    mem[12'h030] = 16'h8040; mem[12'h040] = 16'h8050; mem[12'h050] = 16'h9000;
    mem[12'h031] = 16'h9000; mem[12'h021] = 16'h9000; mem[12'h011] = 16'h9000;
    mem[12'h001] = 16'h9000; mem[12'h002] = 16'h7000;
    run(14, 1'b0, 1'b0, 12'h000, 1'b0, 16'h0000, 1000);
    // byte_ready raised during EXEC1 with pc=3
    clear_mem();
    mem[0] = 16'h4002; mem[2] = 16'h0000; mem[12'h7F6] = 16'h7000;
    run(7, 1'b0, 1'b0, 12'h100, 1'b0, 16'h0000, 2);
    // STP then byte_ready ignored while halted
    clear_mem();
    mem[0] = 16'h4002; mem[2] = 16'h7000;
    run(8, 1'b0, 1'b0, 12'h000, 1'b0, 16'h0000, 3);
    // randomized programs
    for (int r = 0; r < 25; r++) begin
      clear_mem();
      for (int a = 0; a < 128; a++) begin
        op = 4'($urandom_range(0, 15));
        if (op == 4'd7 && $urandom_range(0, 3) != 0) op = 4'd8;
        mem[a] = {op, 12'($urandom_range(0, 127))};
      end
      for (int a = 12'h7F6; a < 12'h7FF; a++) begin
        op = 4'($urandom_range(0, 15));
        mem[a] = {op, 12'($urandom_range(0, 127))};
      end
      run(40, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          12'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 16'($urandom),
          ($urandom_range(0, 3) == 0) ? 1000 : int'($urandom_range(0, 30)));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
